// File: rtl/cache_refill_engine_pkg.sv
// cache_pkg: shared widths, FSM state type and line-base helper for the refill engine.
package cache_pkg;
   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   localparam int LINE_WORDS = 4;
   localparam int LINE_W     = LINE_WORDS * DATA_W;
   localparam int OFFSET_W   = 4;
   typedef enum logic [2:0] {IDLE, FETCH, LOAD, WB, SAVE_ACK, DONE} state_e;
   function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
      return addr & ~ADDR_W'((1 << OFFSET_W) - 1);
   endfunction
endpackage

// File: rtl/cache_refill_engine_if.sv
// cache_refill_engine_if: cache load/save handshake plus the memory bus, engine side is master.
interface cache_refill_engine_if;
   import cache_pkg::*;
   logic              miss_req;
   logic [ADDR_W-1:0] miss_addr;
   logic [ADDR_W-1:0] victim_addr;
   logic              busy;
   logic              done;
   logic              load_enable;
   logic [LINE_W-1:0] write_load_data;
   logic              save_data;
   logic [LINE_W-1:0] write_back_data;
   logic              save_ready;
   logic              load_complate;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;
   modport master (
      input  miss_req, miss_addr, victim_addr, save_data, write_back_data, load_complate,
             mem_rdata, mem_ready,
      output busy, done, load_enable, write_load_data, save_ready, mem_req, mem_we, mem_addr,
             mem_wdata
   );
   modport slave (
      output miss_req, miss_addr, victim_addr, save_data, write_back_data, load_complate,
             mem_rdata, mem_ready,
      input  busy, done, load_enable, write_load_data, save_ready, mem_req, mem_we, mem_addr,
             mem_wdata
   );
endinterface

// File: rtl/cache_refill_engine_refill_beat_ctr.sv
// refill_beat_ctr: 2-bit beat counter with start offset; idx_o is the word slot of the current beat.
module refill_beat_ctr (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load_i,
   input  logic [1:0] start_i,
   input  logic       adv_i,
   output logic [1:0] idx_o,
   output logic       last_o
);
   logic [1:0] cnt_q, off_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         off_q <= '0;
      end else if (load_i) begin
         cnt_q <= '0;
         off_q <= start_i;
      end else if (adv_i) begin
         cnt_q <= cnt_q + 2'd1;
      end
   end
   // 2-bit add wraps the slot modulo 4 for critical-word-first order
   assign idx_o  = cnt_q + off_q;
   assign last_o = &cnt_q;
endmodule

// File: rtl/cache_refill_engine.sv
// cache_refill_engine: 4-beat line refill into the L1 with optional dirty-victim write-back.
// Define CRITICAL_WORD_FIRST_EN to fetch the missing word first and wrap modulo 4.
module cache_refill_engine
   import cache_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   cache_refill_engine_if.master  bus
);
   state_e            state_q, state_d;
   logic [ADDR_W-1:0] base_q, vbase_q;
   logic [LINE_W-1:0] line_q, vdata_q;
   logic [1:0]        idx, start;
   logic              miss_go, wb_go, beat_done, last;

   assign miss_go   = (state_q == IDLE) && bus.miss_req;
   assign wb_go     = (state_q == LOAD) && !bus.load_complate && bus.save_data;
   assign beat_done = bus.mem_req && bus.mem_ready;
`ifdef CRITICAL_WORD_FIRST_EN
   assign start = (state_q == IDLE) ? bus.miss_addr[3:2] : 2'd0;
`else
   assign start = 2'd0;
`endif

   refill_beat_ctr u_ctr (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (miss_go || wb_go),
      .start_i (start),
      .adv_i   (beat_done),
      .idx_o   (idx),
      .last_o  (last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         base_q  <= '0;
         vbase_q <= '0;
         line_q  <= '0;
         vdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (miss_go) base_q <= line_base(bus.miss_addr);
         if (state_q == FETCH && bus.mem_ready) line_q[idx*DATA_W +: DATA_W] <= bus.mem_rdata;
         if (wb_go) begin
            vbase_q <= line_base(bus.victim_addr);
            vdata_q <= bus.write_back_data;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:     state_d = bus.miss_req ? FETCH : IDLE;
         FETCH:    state_d = (beat_done && last) ? LOAD : FETCH;
         LOAD:     state_d = bus.load_complate ? DONE : (bus.save_data ? WB : LOAD);
         WB:       state_d = (beat_done && last) ? SAVE_ACK : WB;
         SAVE_ACK: state_d = bus.load_complate ? DONE : SAVE_ACK;
         default:  state_d = IDLE;
      endcase
      bus.busy            = state_q inside {FETCH, LOAD, WB, SAVE_ACK};
      bus.done            = state_q == DONE;
      bus.load_enable     = state_q inside {LOAD, WB, SAVE_ACK};
      bus.save_ready      = state_q == SAVE_ACK;
      bus.mem_req         = state_q inside {FETCH, WB};
      bus.mem_we          = state_q == WB;
      bus.mem_addr        = (state_q == FETCH) ? base_q | ADDR_W'({idx, 2'b00}) :
                            (state_q == WB)    ? vbase_q | ADDR_W'({idx, 2'b00}) : '0;
      bus.mem_wdata       = (state_q == WB) ? vdata_q[idx*DATA_W +: DATA_W] : '0;
      bus.write_load_data = line_q;
   end
endmodule

// File: tb/tb_cache_refill_engine.sv
// tb_cache_refill_engine: directed checks of refill, write-back, wait states, priority and reset.
module tb_cache_refill_engine;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] mem [4];
   int          checks = 0;
   int          errors = 0;
   int          wr_cnt = 0;
   int          sr_cnt = 0;

   cache_refill_engine_if bus();

   cache_refill_engine dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   assign bus.mem_rdata = mem[bus.mem_addr[3:2]];

   always @(posedge clk) begin
      if (bus.mem_req && bus.mem_ready && bus.mem_we) wr_cnt <= wr_cnt + 1;
      if (bus.save_ready) sr_cnt <= sr_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_busy"}, bus.busy, 1'b0);
      chk({tag, "_done"}, bus.done, 1'b0);
      chk({tag, "_load_en"}, bus.load_enable, 1'b0);
      chk({tag, "_save_rdy"}, bus.save_ready, 1'b0);
      chk({tag, "_mem_req"}, bus.mem_req, 1'b0);
      chk({tag, "_mem_we"}, bus.mem_we, 1'b0);
      chk({tag, "_mem_addr"}, bus.mem_addr, 32'h0);
      chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
   endtask

   task automatic start_miss(input logic [31:0] addr);
      bus.miss_req  = 1'b1;
      bus.miss_addr = addr;
      tick();
      bus.miss_req  = 1'b0;
   endtask

   task automatic wait_load();
      for (int i = 0; i < 40 && !bus.load_enable; i++) tick();
      chk("wait_load_enable", bus.load_enable, 1'b1);
   endtask

   task automatic finish_load(input string tag);
      bus.load_complate = 1'b1;
      tick();
      bus.load_complate = 1'b0;
      chk({tag, "_done"}, bus.done, 1'b1);
      chk({tag, "_busy_done"}, bus.busy, 1'b0);
      chk({tag, "_load_en_done"}, bus.load_enable, 1'b0);
      tick();
      chk({tag, "_done_pulse"}, bus.done, 1'b0);
   endtask

   initial begin
      int n0;
      logic [31:0] exp_a;
      logic [127:0] wb_line;
      bus.miss_req        = 1'b0;
      bus.miss_addr       = '0;
      bus.victim_addr     = '0;
      bus.save_data       = 1'b0;
      bus.write_back_data = '0;
      bus.load_complate   = 1'b0;
      bus.mem_ready       = 1'b1;
      mem = '{32'h0, 32'h0, 32'h0, 32'h0};
      #1;
      chk_idle_outputs("reset");
      chk("reset_line", bus.write_load_data, 128'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();

      // clean miss, zero-wait memory
      mem = '{32'h1111, 32'h0, 32'h1414, 32'h0};
      n0 = sr_cnt;
      start_miss(32'h0000_0000);
      chk("clean_busy", bus.busy, 1'b1);
      for (int i = 0; i < 4; i++) begin
         chk("clean_req", bus.mem_req, 1'b1);
         chk("clean_we", bus.mem_we, 1'b0);
         chk("clean_addr", bus.mem_addr, 32'(4 * i));
         tick();
      end
      chk("clean_load_en", bus.load_enable, 1'b1);
      chk("clean_req_off", bus.mem_req, 1'b0);
      chk("clean_line", bus.write_load_data, 128'h0000_0000_0000_1414_0000_0000_0000_1111);
      tick();
      chk("clean_line_hold", bus.write_load_data, 128'h0000_0000_0000_1414_0000_0000_0000_1111);
      finish_load("clean");
      chk("clean_no_save_ready", sr_cnt - n0, 0);

      // dirty victim write-back
      mem = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
      wb_line = 128'h4444_4444_3333_3333_2222_2222_7777_BBBB;
      start_miss(32'h4000_0010);
      chk("dirty_fetch_addr0", bus.mem_addr, 32'h4000_0010);
      wait_load();
      bus.save_data       = 1'b1;
      bus.victim_addr     = 32'hB000_0000;
      bus.write_back_data = wb_line;
      tick();
      bus.save_data       = 1'b0;
      bus.write_back_data = '0;
      for (int i = 0; i < 4; i++) begin
         chk("wb_req", bus.mem_req, 1'b1);
         chk("wb_we", bus.mem_we, 1'b1);
         chk("wb_addr", bus.mem_addr, 32'hB000_0000 + 32'(4 * i));
         chk("wb_wdata", bus.mem_wdata, wb_line[i*32 +: 32]);
         chk("wb_load_en", bus.load_enable, 1'b1);
         tick();
      end
      chk("sack_ready", bus.save_ready, 1'b1);
      chk("sack_load_en", bus.load_enable, 1'b1);
      chk("sack_req_off", bus.mem_req, 1'b0);
      chk("sack_line", bus.write_load_data, 128'h0000_00A3_0000_00A2_0000_00A1_0000_00A0);
      tick();
      chk("sack_hold", bus.save_ready, 1'b1);
      bus.load_complate = 1'b1;
      tick();
      bus.load_complate = 1'b0;
      chk("sack_done", bus.done, 1'b1);
      chk("sack_ready_off", bus.save_ready, 1'b0);
      tick();
      chk("sack_idle", bus.busy, 1'b0);

      // three wait cycles per beat
      mem = '{32'hDEAD_0000, 32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003};
      bus.mem_ready = 1'b0;
      start_miss(32'h0000_1230);
      for (int b = 0; b < 4; b++) begin
         for (int w = 0; w < 4; w++) begin
            bus.mem_ready = (w == 3);
            chk("wait_req", bus.mem_req, 1'b1);
            chk("wait_addr", bus.mem_addr, 32'h0000_1230 + 32'(4 * b));
            tick();
         end
      end
      bus.mem_ready = 1'b1;
      chk("wait_load_en", bus.load_enable, 1'b1);
      chk("wait_line", bus.write_load_data, 128'hDEAD_0003_DEAD_0002_DEAD_0001_DEAD_0000);
      finish_load("wait");

      // save_data and load_complate together: load_complate wins
      n0 = wr_cnt;
      start_miss(32'h0000_0040);
      wait_load();
      bus.save_data     = 1'b1;
      bus.victim_addr   = 32'hC000_0000;
      bus.load_complate = 1'b1;
      tick();
      bus.save_data     = 1'b0;
      bus.load_complate = 1'b0;
      chk("simul_done", bus.done, 1'b1);
      chk("simul_req", bus.mem_req, 1'b0);
      tick();
      chk("simul_no_writes", wr_cnt - n0, 0);

      // async reset during write-back beat 2
      start_miss(32'h0000_0080);
      wait_load();
      bus.save_data       = 1'b1;
      bus.victim_addr     = 32'hD000_0010;
      bus.write_back_data = wb_line;
      tick();
      bus.save_data = 1'b0;
      tick();
      tick();
      chk("rst_wb_beat2_addr", bus.mem_addr, 32'hD000_0018);
      rst_n = 1'b0;
      #1;
      chk_idle_outputs("midwb_rst");
      chk("midwb_rst_line", bus.write_load_data, 128'h0);
      rst_n = 1'b1;
      tick();
      start_miss(32'h2000_0000);
      chk("restart_req", bus.mem_req, 1'b1);
      chk("restart_we", bus.mem_we, 1'b0);
      chk("restart_addr", bus.mem_addr, 32'h2000_0000);
      wait_load();
      finish_load("restart");

      // fetch order from a mid-line miss
      mem = '{32'h10, 32'h20, 32'h30, 32'h40};
      start_miss(32'hA000_0008);
      for (int i = 0; i < 4; i++) begin
`ifdef CRITICAL_WORD_FIRST_EN
         exp_a = 32'hA000_0000 + 32'(4 * ((i + 2) % 4));
`else
         exp_a = 32'hA000_0000 + 32'(4 * i);
`endif
         chk("order_addr", bus.mem_addr, exp_a);
         tick();
      end
      chk("order_load_en", bus.load_enable, 1'b1);
      chk("order_line", bus.write_load_data, 128'h0000_0040_0000_0030_0000_0020_0000_0010);
      finish_load("order");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
